// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter arbiter: FSM encodings and sizing.
package uart_pkg;
   localparam int NREQ         = 4;
   localparam int START_TO_DEF = 32;
   localparam int CNT_W        = 5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      START   = 2'd1,
      WAIT_HI = 2'd2,
      WAIT_LO = 2'd3
   } state_t;
endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin pick: first requester at or after (last+1) mod 4 wins.
module uart_rr_pick
   import uart_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic [1:0]      last,
   output logic [1:0]      winner,
   output logic            valid
);
   // Walk from the lowest priority upward so the highest-priority hit overwrites.
   always_comb begin
      winner = last;
      valid  = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (req[last + 2'(i + 1)]) begin
            winner = last + 2'(i + 1);
            valid  = 1'b1;
         end
      end
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among four byte requesters,
// with a start-timeout guard on the transmitter's busy handshake.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NREQ     = uart_pkg::NREQ,
   parameter int START_TO = uart_pkg::START_TO_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [8*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   ack,
   output logic [NREQ-1:0]   done,
   output logic [7:0]        tx_data,
   output logic              tx_start,
   input  logic              tx_busy,
   output logic [1:0]        tx_ch,
   output logic              err
);
   localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(START_TO - 1);
   localparam logic [NREQ-1:0]  ONE    = NREQ'(1);

   state_t           state, nxt;
   logic [1:0]       last, winner;
   logic             valid;
   logic [CNT_W-1:0] cnt;
   logic             grant_go, to_hit, frame_end;

   uart_rr_pick u_pick (
      .req    (req),
      .last   (last),
      .winner (winner),
      .valid  (valid)
   );

   assign grant_go  = (state == IDLE) && valid && !tx_busy;
   assign to_hit    = (state == WAIT_HI) && !tx_busy && (cnt == TO_LIM);
   assign frame_end = (state == WAIT_LO) && !tx_busy;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (grant_go) nxt = START;
         START:   nxt = WAIT_HI;
         WAIT_HI: if (tx_busy) nxt = WAIT_LO;
                  else if (to_hit) nxt = IDLE;
         WAIT_LO: if (!tx_busy) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      tx_start = (state == START);
      ack      = (state == START) ? gnt : '0;
   end

   // done/err are registered so they land in the IDLE cycle where a new grant may already be chosen.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt     <= '0;
         done    <= '0;
         err     <= 1'b0;
         tx_data <= '0;
         tx_ch   <= 2'd3;
         last    <= 2'd3;
         cnt     <= '0;
      end else begin
         done <= '0;
         err  <= 1'b0;
         if (grant_go) begin
            gnt     <= ONE << winner;
            tx_data <= req_data[8*winner +: 8];
            tx_ch   <= winner;
         end
         if (state != WAIT_HI || tx_busy) cnt <= '0;
         else if (cnt != '1)              cnt <= cnt + 1'b1;
         if (to_hit) begin
            err  <= 1'b1;
            gnt  <= '0;
            last <= tx_ch;
         end
         if (frame_end) begin
            done <= gnt;
            gnt  <= '0;
            last <= tx_ch;
         end
      end
   end
endmodule
